// File: rtl/quad_encoder_tx.sv
// Quadrature encoder emulator: walks enc_a/enc_b through whole detents so a
// paired encoder-counting receiver moves its paddle to the requested row.
module quad_encoder_tx #(
   parameter int PHASE_DIV = 1000,
   parameter int HOME_Y    = 28,
   parameter int MIN_Y     = 0,
   parameter int MAX_Y     = 58
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       home,
   input  logic       target_valid,
   input  logic [5:0] target_y,
   output logic       enc_a,
   output logic       enc_b,
   output logic [5:0] pos_y,
   output logic       busy,
   output logic       step
);

   localparam int            TW    = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
   localparam logic [TW-1:0] TLAST = TW'(PHASE_DIV - 1);
   localparam logic [5:0]    HOME6 = 6'(HOME_Y);

   typedef enum logic [2:0] {
      S_IDLE,
      S_P1,
      S_P2,
      S_P3,
      S_P4
   } state_t;

   state_t        r_state;
   logic [TW-1:0] r_timer;
   logic          r_dir_up;
   logic          r_enc_a;
   logic          r_enc_b;
   logic [5:0]    r_pos;
   logic [5:0]    r_tgt;
   logic          r_step;

   state_t        w_state_nxt;
   logic [TW-1:0] w_timer_nxt;
   logic          w_dir_nxt;
   logic          w_start;
   logic          w_want;
   logic          w_up;
   logic          w_phase_end;
   logic [1:0]    w_code_nxt;
   logic          w_init;

   function automatic logic [5:0] clamp_y(input logic [5:0] y);
      if (int'(y) < MIN_Y)      return 6'(MIN_Y);
      else if (int'(y) > MAX_Y) return 6'(MAX_Y);
      else                      return y;
   endfunction

   // {a,b} driven while in a given phase; P1/P3 swap with direction so the
   // receiver sees A lead B going up and B lead A going down.
   function automatic logic [1:0] phase_code(input state_t s, input logic up);
      case (s)
         S_P1:    return up ? 2'b10 : 2'b01;
         S_P2:    return 2'b11;
         S_P3:    return up ? 2'b01 : 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   assign w_init      = reset | home;
   assign w_want      = enable && (r_pos != r_tgt);
   assign w_up        = (r_tgt > r_pos);
   assign w_phase_end = (r_timer == TLAST);

   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_dir_nxt   = r_dir_up;
      w_start     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_timer_nxt = '0;
            if (w_want) begin
               w_state_nxt = S_P1;
               w_dir_nxt   = w_up;
               w_start     = 1'b1;
            end
         end
         S_P1, S_P2, S_P3: begin
            if (w_phase_end) begin
               w_timer_nxt = '0;
               case (r_state)
                  S_P1:    w_state_nxt = S_P2;
                  S_P2:    w_state_nxt = S_P3;
                  default: w_state_nxt = S_P4;
               endcase
            end else begin
               w_timer_nxt = r_timer + TW'(1);
            end
         end
         S_P4: begin
            // The 00 dwell always runs to completion; only then is the
            // latest target and enable consulted for another detent.
            if (w_phase_end) begin
               w_timer_nxt = '0;
               if (w_want) begin
                  w_state_nxt = S_P1;
                  w_dir_nxt   = w_up;
                  w_start     = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_timer_nxt = r_timer + TW'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
         end
      endcase
      w_code_nxt = phase_code(w_state_nxt, w_dir_nxt);
   end

   always_ff @(posedge clk) begin
      if (w_init) begin
         r_state  <= S_IDLE;
         r_timer  <= '0;
         r_dir_up <= 1'b0;
         r_enc_a  <= 1'b0;
         r_enc_b  <= 1'b0;
         r_pos    <= HOME6;
         r_tgt    <= HOME6;
         r_step   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_timer  <= w_timer_nxt;
         r_dir_up <= w_dir_nxt;
         r_enc_a  <= w_code_nxt[1];
         r_enc_b  <= w_code_nxt[0];
         r_step   <= w_start;
         // Shadow count moves on the edge that enters P1, with the encoder code.
         if (w_start) begin
            r_pos <= w_dir_nxt ? (r_pos + 6'd1) : (r_pos - 6'd1);
         end
         if (target_valid) begin
            r_tgt <= clamp_y(target_y);
         end
      end
   end

   assign enc_a = r_enc_a;
   assign enc_b = r_enc_b;
   assign pos_y = r_pos;
   assign busy  = (r_state != S_IDLE);
   assign step  = r_step;

endmodule

// File: tb/tb_quad_encoder_tx.sv
// Randomized scoreboard bench for quad_encoder_tx: expected paddle positions are
// queued per move and popped by an independent encoder-watching monitor.
module tb_quad_encoder_tx;

   localparam int PD   = 4;
   localparam int HOME = 28;
   localparam int MAXY = 58;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b1;
   logic       home = 1'b0;
   logic       target_valid = 1'b0;
   logic [5:0] target_y = 6'd0;
   logic       enc_a, enc_b, busy, step;
   logic [5:0] pos_y;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int steps_seen = 0;
   int toggles = 0;
   int model_pos = HOME;
   int sb[$];

   quad_encoder_tx #(.PHASE_DIV(PD), .HOME_Y(HOME), .MIN_Y(0), .MAX_Y(MAXY)) dut (
      .clk(clk), .reset(reset), .enable(enable), .home(home),
      .target_valid(target_valid), .target_y(target_y),
      .enc_a(enc_a), .enc_b(enc_b), .pos_y(pos_y), .busy(busy), .step(step)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, actual=hung required=done");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      errors++;
      $display("FAIL %s timeout actual=busy required=idle (cycle %0d)", nm, cyc);
   endtask

   function automatic int clampm(input int t);
      return (t > MAXY) ? MAXY : ((t < 0) ? 0 : t);
   endfunction

   // One expected position per detent, walking from 'from' toward 'to'.
   task automatic push_path(input int from, input int to);
      int p;
      p = from;
      while (p != to) begin
         p = (to > p) ? p + 1 : p - 1;
         sb.push_back(p);
      end
   endtask

   // ---------------- monitor: receiver model, code legality, scoreboard pops
   logic [1:0] cur;
   logic [1:0] prev = 2'b00;
   int  run = PD;
   int  rx = HOME;
   bit  abort_pend = 1'b0;
   bit  in_move = 1'b0;
   int  last_step_cyc = 0;
   int  e;

   initial forever begin
      @(negedge clk);
      cur = {enc_a, enc_b};
      if (abort_pend) begin
         rx = HOME;
         prev = cur;
         run = PD;
         abort_pend = 1'b0;
         in_move = 1'b0;
      end else if (cur != prev) begin
         toggles++;
         chk("one_bit_per_edge", $countones(cur ^ prev), 1);
         if (prev != 2'b00) chk("phase_hold", run, PD);
         else               chk("dwell00_min", int'(run >= PD), 1);
         if (!prev[1] && cur[1] && !cur[0]) rx++;
         if (!prev[0] && cur[0] && !cur[1]) rx--;
         run = 1;
         prev = cur;
      end else begin
         run++;
      end
      if (!busy) in_move = 1'b0;
      if (step) begin
         steps_seen++;
         if (sb.size() == 0) begin
            chk("unexpected_step_pos", int'(pos_y), -1);
         end else begin
            e = sb.pop_front();
            chk("pos_y", int'(pos_y), e);
            chk("receiver_count", rx, e);
         end
         if (in_move) chk("step_gap", cyc - last_step_cyc, 4 * PD);
         in_move = 1'b1;
         last_step_cyc = cyc;
      end
      if (reset || home) abort_pend = 1'b1;
   end

   // ---------------- stimulus helpers
   task automatic set_target(input int t);
      @(posedge clk); #1;
      target_y = 6'(t);
      target_valid = 1'b1;
      @(posedge clk); #1;
      target_valid = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      bit ok;
      ok = 1'b0;
      repeat (3) @(posedge clk);
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (!busy && sb.size() == 0) begin ok = 1'b1; break; end
      end
      if (!ok) timeout(nm);
   endtask

   task automatic wait_code(input logic [1:0] code, input string nm);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if ({enc_a, enc_b} == code) begin ok = 1'b1; break; end
      end
      if (!ok) timeout(nm);
   endtask

   task automatic move_to(input int t);
      int ct;
      ct = clampm(t);
      push_path(model_pos, ct);
      set_target(t);
      wait_idle("move");
      chk("pos_final", int'(pos_y), ct);
      model_pos = ct;
   endtask

   task automatic move_retarget(input int t1, input int t2);
      int c1, c2, len, k, base, p;
      bit ok;
      c1 = clampm(t1);
      c2 = clampm(t2);
      len = (c1 > model_pos) ? c1 - model_pos : model_pos - c1;
      if (len == 0) begin
         move_to(t2);
         return;
      end
      push_path(model_pos, c1);
      base = steps_seen;
      k = $urandom_range(1, len);
      set_target(t1);
      ok = 1'b0;
      for (int i = 0; i < k * 4 * PD + 20; i++) begin
         @(posedge clk); #1;
         if (steps_seen >= base + k) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         timeout("retarget_wait");
         return;
      end
      // The detent in flight completes; the new target governs from there on.
      p = (c1 > model_pos) ? model_pos + k : model_pos - k;
      sb.delete();
      push_path(p, c2);
      set_target(t2);
      wait_idle("retarget");
      chk("pos_after_retarget", int'(pos_y), c2);
      model_pos = c2;
   endtask

   task automatic pulse(input bit use_reset);
      @(posedge clk); #1;
      if (use_reset) reset = 1'b1; else home = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      home = 1'b0;
   endtask

   // ---------------- main sequence
   int t0, s0;

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("reset_enc", int'({enc_a, enc_b}), 0);
      chk("reset_pos", int'(pos_y), HOME);
      chk("reset_busy", int'(busy), 0);
      chk("reset_step", int'(step), 0);

      t0 = toggles;
      repeat (100) @(posedge clk);
      #1 chk("idle_no_toggles", toggles - t0, 0);

      // Up move with first-detent latency
      push_path(HOME, 30);
      @(posedge clk); #1;
      target_y = 6'd30;
      target_valid = 1'b1;
      @(posedge clk); #1;
      target_valid = 1'b0;
      chk("lat_busy_n1", int'(busy), 0);
      chk("lat_pos_n1", int'(pos_y), HOME);
      @(posedge clk); #1;
      chk("lat_busy_n2", int'(busy), 1);
      chk("lat_pos_n2", int'(pos_y), 29);
      chk("lat_code_n2", int'({enc_a, enc_b}), 2);
      wait_idle("up_move");
      chk("up_final", int'(pos_y), 30);
      model_pos = 30;

      move_to(26);
      move_to(57);
      move_to(63);
      move_to(2);
      move_to(0);

      // Retarget during P2 of the first up detent
      pulse(1'b0);
      chk("home_idle_pos", int'(pos_y), HOME);
      model_pos = HOME;
      sb.push_back(29); sb.push_back(28); sb.push_back(27); sb.push_back(26);
      set_target(30);
      wait_code(2'b11, "wait_p2");
      set_target(26);
      wait_idle("retarget_directed");
      chk("retarget_final", int'(pos_y), 26);
      model_pos = 26;

      // Home, then reset, each in P2 of an up detent
      for (int r = 0; r < 2; r++) begin
         sb.push_back(model_pos + 1);
         set_target(40);
         wait_code(2'b11, "wait_p2_abort");
         chk("abort_queue_drained", sb.size(), 0);
         sb.delete();
         pulse(r == 1);
         chk("abort_enc", int'({enc_a, enc_b}), 0);
         chk("abort_pos", int'(pos_y), HOME);
         chk("abort_busy", int'(busy), 0);
         model_pos = HOME;
         s0 = steps_seen;
         repeat (100) @(posedge clk);
         #1 chk("abort_no_steps", steps_seen - s0, 0);
      end

      // enable dropped in P1: detent finishes, motion resumes on re-enable
      sb.push_back(29);
      set_target(32);
      wait_code(2'b10, "wait_p1");
      enable = 1'b0;
      wait_idle("enable_low");
      chk("enable_low_pos", int'(pos_y), 29);
      s0 = steps_seen;
      repeat (100) @(posedge clk);
      #1 chk("enable_low_no_steps", steps_seen - s0, 0);
      push_path(29, 32);
      enable = 1'b1;
      wait_idle("reenable");
      chk("reenable_pos", int'(pos_y), 32);
      model_pos = 32;

      // Random moves, some retargeted mid-move
      for (int n = 0; n < 14; n++) begin
         if ($urandom_range(0, 2) == 0)
            move_retarget(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
         else
            move_to(int'($urandom_range(0, 63)));
      end

      repeat (10) @(posedge clk);
      #1 chk("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
